// File: rtl/sha_block_sequencer.sv
// SHA-256 control sequencer: hash/message fetch, 64 rounds per block, fold, hash write-back.
// Optional `abort` input is present when SEQ_ABORT_EN is defined.
module sha_block_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2,
  parameter int H_BASE   = 0,
  parameter int MSG_BASE = 8,
  parameter int OUT_BASE = 200
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [5:0]        num_blocks,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic              hash_load_en,
  output logic [2:0]        hash_load_idx,
  output logic              msg_load_en,
  output logic [3:0]        msg_load_idx,
  output logic              round_en,
  output logic [5:0]        round_idx,
  output logic              hash_update_en,
  output logic [2:0]        out_word_sel,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_H, S_LOAD_M, S_DRAIN, S_ROUNDS, S_UPDATE, S_WRITE, S_DONE
  } state_t;

  localparam logic [6:0] DRAIN_LAST = 7'(READ_LAT - 1);

  logic abort_w;
`ifdef SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [5:0]          blk_q, blk_d;
  logic [5:0]          nblk_q, nblk_d;
  logic                mem_read_en_q, mem_read_en_d;
  logic [ADDR_W-1:0]   mem_read_addr_q, mem_read_addr_d;
  logic                rd_kind_q, rd_kind_d;
  logic [3:0]          rd_idx_q, rd_idx_d;
  logic                mem_write_en_q, mem_write_en_d;
  logic [ADDR_W-1:0]   mem_write_addr_q, mem_write_addr_d;
  logic                round_en_q, round_en_d;
  logic [5:0]          round_idx_q, round_idx_d;
  logic                hash_update_en_q, hash_update_en_d;
  logic [2:0]          out_word_sel_q, out_word_sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [READ_LAT-1:0]      pv_q, pv_d;
  logic [READ_LAT-1:0]      pk_q, pk_d;
  logic [READ_LAT-1:0][3:0] pi_q, pi_d;
  logic [31:0]         h_addr, m_addr, w_addr;

  // Next state and counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    nblk_d  = nblk_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nblk_d  = num_blocks;
          blk_d   = 6'd0;
          cnt_d   = 7'd0;
          state_d = (num_blocks != 6'd0) ? S_LOAD_H : S_DONE;
        end
      end
      S_LOAD_H: begin
        if (cnt_q == 7'd7) begin
          state_d = S_LOAD_M;
          cnt_d   = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_LOAD_M: begin
        if (cnt_q == 7'd15) begin
          state_d = S_DRAIN;
          cnt_d   = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_ROUNDS;
          cnt_d   = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_ROUNDS: begin
        if (cnt_q == 7'd63) begin
          state_d = S_UPDATE;
          cnt_d   = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_UPDATE: begin
        blk_d   = blk_q + 6'd1;
        cnt_d   = 7'd0;
        state_d = ((blk_q + 6'd1) < nblk_q) ? S_LOAD_M : S_WRITE;
      end
      S_WRITE: begin
        if (cnt_q == 7'd7) begin
          state_d = S_DONE;
          cnt_d   = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_w && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = 7'd0;
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    h_addr = 32'(H_BASE) + {25'd0, cnt_d};
    m_addr = 32'(MSG_BASE) + {22'd0, blk_d, 4'd0} + {25'd0, cnt_d};
    w_addr = 32'(OUT_BASE) + {25'd0, cnt_d};

    mem_read_en_d    = (state_d == S_LOAD_H) || (state_d == S_LOAD_M);
    rd_kind_d        = (state_d == S_LOAD_M);
    rd_idx_d         = mem_read_en_d ? cnt_d[3:0] : 4'd0;
    mem_read_addr_d  = '0;
    if (state_d == S_LOAD_H) mem_read_addr_d = h_addr[ADDR_W-1:0];
    if (state_d == S_LOAD_M) mem_read_addr_d = m_addr[ADDR_W-1:0];
    mem_write_en_d   = (state_d == S_WRITE);
    mem_write_addr_d = mem_write_en_d ? w_addr[ADDR_W-1:0] : '0;
    out_word_sel_d   = mem_write_en_d ? cnt_d[2:0] : 3'd0;
    round_en_d       = (state_d == S_ROUNDS);
    round_idx_d      = round_en_d ? cnt_d[5:0] : 6'd0;
    hash_update_en_d = (state_d == S_UPDATE);
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
  end

  // Read-return delay line: one (valid, kind, idx) slot per cycle of latency
  always_comb begin
    pv_d = pv_q;
    pk_d = pk_q;
    pi_d = pi_q;
    for (int i = READ_LAT - 1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      pk_d[i] = pk_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    pv_d[0] = mem_read_en_q;
    pk_d[0] = rd_kind_q;
    pi_d[0] = rd_idx_q;
    if (abort_w && (state_q != S_IDLE)) begin
      pv_d = '0;
      pk_d = '0;
      pi_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= 7'd0;
      blk_q            <= 6'd0;
      nblk_q           <= 6'd0;
      mem_read_en_q    <= 1'b0;
      mem_read_addr_q  <= '0;
      rd_kind_q        <= 1'b0;
      rd_idx_q         <= 4'd0;
      mem_write_en_q   <= 1'b0;
      mem_write_addr_q <= '0;
      round_en_q       <= 1'b0;
      round_idx_q      <= 6'd0;
      hash_update_en_q <= 1'b0;
      out_word_sel_q   <= 3'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pv_q             <= '0;
      pk_q             <= '0;
      pi_q             <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      blk_q            <= blk_d;
      nblk_q           <= nblk_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_read_addr_q  <= mem_read_addr_d;
      rd_kind_q        <= rd_kind_d;
      rd_idx_q         <= rd_idx_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_addr_q <= mem_write_addr_d;
      round_en_q       <= round_en_d;
      round_idx_q      <= round_idx_d;
      hash_update_en_q <= hash_update_en_d;
      out_word_sel_q   <= out_word_sel_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pv_q             <= pv_d;
      pk_q             <= pk_d;
      pi_q             <= pi_d;
    end
  end

  assign mem_read_en    = mem_read_en_q;
  assign mem_read_addr  = mem_read_addr_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_addr = mem_write_addr_q;
  assign hash_load_en   = pv_q[READ_LAT-1] & ~pk_q[READ_LAT-1];
  assign hash_load_idx  = hash_load_en ? pi_q[READ_LAT-1][2:0] : 3'd0;
  assign msg_load_en    = pv_q[READ_LAT-1] & pk_q[READ_LAT-1];
  assign msg_load_idx   = msg_load_en ? pi_q[READ_LAT-1] : 4'd0;
  assign round_en       = round_en_q;
  assign round_idx      = round_idx_q;
  assign hash_update_en = hash_update_en_q;
  assign out_word_sel   = out_word_sel_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/sha_block_sequencer.md
Name: sha_block_sequencer

Overview:
Control FSM for the SHA-256 datapath. On `start` it performs these steps in order:
- fetches the 8 initial hash words from memory;
- fetches each 16-word message block;
- runs 64 compression rounds per block;
- folds the round result into the hash;
- writes the 8 final hash words back to memory.

It owns the memory address and strobes and the datapath enables. It performs no arithmetic on hash or message data.

Parameters:
ADDR_W, 8, memory address width
READ_LAT, 2, memory read latency in cycles (address/read_en to data valid), 1..4
H_BASE, 0, address of initial hash word 0
MSG_BASE, 8, address of message word 0 of block 0
OUT_BASE, 200, address where final hash word 0 is written

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  start pulse, sampled in IDLE only
num_blocks  in  6  message blocks to process, latched on start
mem_read_en  out  1  memory read strobe
mem_read_addr  out  ADDR_W  read address
mem_write_en  out  1  memory write strobe
mem_write_addr  out  ADDR_W  write address
hash_load_en  out  1  returning data is initial hash word hash_load_idx
hash_load_idx  out  3  hash word index
msg_load_en  out  1  returning data is message word msg_load_idx
msg_load_idx  out  4  message word index
round_en  out  1  datapath executes round round_idx
round_idx  out  6  round number 0..63
hash_update_en  out  1  one-cycle fold of working vars into hash
out_word_sel  out  3  hash word driven to memory write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock/reset: clock `clock`; reset `reset`, synchronous, active-high.
- Reset values: all outputs 0, FSM in IDLE, counters 0, read-return pipeline cleared. Reset mid-operation aborts immediately; in-flight read returns produce no load strobes.
- States: IDLE, LOAD_H, LOAD_M, DRAIN, ROUNDS, UPDATE, WRITE, DONE.
- IDLE:
  - start=1 and num_blocks!=0: latch num_blocks, blk=0, go to LOAD_H.
  - start=1 and num_blocks==0: go to DONE with no memory access.
- LOAD_H (8 cycles): mem_read_en=1, mem_read_addr=H_BASE+i for i=0..7, then LOAD_M.
- LOAD_M (16 cycles): mem_read_en=1, mem_read_addr=MSG_BASE+16*blk+j for j=0..15, then DRAIN. Address arithmetic wraps modulo 2^ADDR_W.
- Read-return pipeline:
  - A READ_LAT-deep delay line carries (valid, kind, idx) for each read.
  - Exactly READ_LAT cycles after issue, hash_load_en or msg_load_en pulses with the matching idx.
  - LOAD_H data may return while LOAD_M is issuing; both strobes are never high in the same cycle.
- DRAIN (READ_LAT cycles): no reads; the last msg_load_en occurs in DRAIN's final cycle; then ROUNDS.
- ROUNDS (64 cycles): round_en=1, round_idx=0..63; then UPDATE.
- UPDATE (1 cycle): hash_update_en=1, blk increments.
  - If blk < latched num_blocks: go to LOAD_M (LOAD_H is not repeated).
  - Otherwise: go to WRITE.
- WRITE (8 cycles): mem_write_en=1, mem_write_addr=OUT_BASE+k, out_word_sel=k for k=0..7; then DONE.
- DONE (1 cycle): done=1, busy=1; then IDLE.
- In IDLE, busy=0.
- start is ignored whenever the FSM is not in IDLE.
- Latency with READ_LAT=2, start sampled at cycle 0:
  - LOAD_H 1–8, LOAD_M 9–24, DRAIN 25–26, ROUNDS 27–90, UPDATE 91, WRITE 92–99, done at cycle 100.
  - Each additional block adds 16+READ_LAT+64+1 cycles.
- Read and write strobes are never high in the same cycle.

Optional Feature:
SEQ_ABORT_EN: when defined, an extra input port `abort` (1 bit) is present.
- abort=1 in any non-IDLE state forces IDLE on the next edge: all outputs 0, read-return pipeline cleared, no done pulse, no further memory writes.
- abort has priority over state transitions; reset has priority over abort.
- abort in IDLE has no effect.
- When SEQ_ABORT_EN is not defined, the port is absent and the only exit from an operation is reset.

Test Plan:
1. Single block: num_blocks=1, READ_LAT=2, start pulse at cycle 0.
   - hash_load_en at cycles 3–10 with idx 0..7; msg_load_en at cycles 11–26 with idx 0..15.
   - round_en at cycles 27–90; hash_update_en at cycle 91; writes to addresses 200..207 at cycles 92–99; done at cycle 100.
2. Three blocks: num_blocks=3.
   - Block 2 reads addresses 40..55; LOAD_H occurs once; exactly 3 hash_update_en pulses; done at cycle 266.
3. num_blocks=0: done at cycle 1, busy high only in cycle 1, no memory strobes.
4. Second start while busy, at cycle 50: ignored, with identical timing to scenario 1. A start in the cycle after done begins a new operation.
5. Reset asserted at cycle 20 (during LOAD_M): all outputs 0 from cycle 21, no load strobes from in-flight reads; a new start behaves as in scenario 1.
6. SEQ_ABORT_EN defined, abort at cycle 60 (ROUNDS): IDLE from cycle 61, round_en=0, no writes, no done pulse.
